// File: rtl/va_adc_readout_seq.sv
// rtl/va_adc_readout_seq.sv - VA front-end readout sequencer: hold, shift-out, ADC convert, FIFO formatting
// Tick-paced FSM with FIFO backpressure, ADC timeout recovery, zero suppression and calibration readout.
module va_adc_readout_seq #(
  parameter int N_CHN      = 32,
  parameter int CLK_DIV    = 4,
  parameter int HOLD_DLY   = 16,
  parameter int SETTLE_DLY = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_sys,
  input  logic        rstn,
  input  logic        trig,
  input  logic        cali_mode,
  input  logic [6:0]  cali_chn,
  input  logic        zs_en,
  input  logic [15:0] zs_thresh,
  output logic        va_hold,
  output logic        va_shiftb,
  output logic        va_ckb,
  output logic        va_dreset,
  input  logic        va_shift_out,
  output logic        adc_nrc,
  input  logic        adc_nbusy,
  input  logic [15:0] adc_data,
  output logic [15:0] fifo_data,
  output logic        fifo_we,
  input  logic        fifo_full,
  output logic        busy_n,
  output logic        err_timeout
);

  localparam int          DW       = $clog2(CLK_DIV);
  localparam logic [15:0] C_HOLD   = 16'(HOLD_DLY - 1);
  localparam logic [15:0] C_SETTLE = 16'(SETTLE_DLY - 1);
  localparam logic [15:0] C_TOUT   = 16'(TIMEOUT);
  localparam logic [7:0]  C_NCHN   = 8'(N_CHN);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLDW, S_HOLD, S_SHIFT, S_CKLO, S_CHECK, S_SETTLE,
    S_CONV, S_WLO, S_WHI, S_WHDR, S_WDAT, S_NEXT, S_TRAIL
  } state_t;

  state_t        r_state, w_nstate;
  logic [DW-1:0] r_div;
  logic          w_tick;
  logic          r_trig_s1, r_trig_s2, r_trig_d, r_trig_req;
  logic          w_trig_rise;
  logic [15:0]   r_cnt;
  logic [7:0]    r_chn;
  logic [15:0]   r_data;
  logic [7:0]    r_nwr;
  logic          r_tout;
  logic [7:0]    r_trig_id;
  logic [5:0]    r_evt_id;
  logic          r_err;
  logic          r_hold, r_shiftb, r_ckb, r_dreset, r_nrc;
  logic          w_skip, w_write, w_timeout;
  logic [15:0]   w_word;

  assign w_tick = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // A request is consumed on every tick, so edges arriving outside IDLE are dropped.
  assign w_trig_rise = r_trig_s2 & ~r_trig_d;

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      r_trig_s1  <= 1'b0;
      r_trig_s2  <= 1'b0;
      r_trig_d   <= 1'b0;
      r_trig_req <= 1'b0;
    end else begin
      r_trig_s1 <= trig;
      r_trig_s2 <= r_trig_s1;
      r_trig_d  <= r_trig_s2;
      if (w_tick) begin
        r_trig_req <= w_trig_rise;
      end else if (w_trig_rise) begin
        r_trig_req <= 1'b1;
      end
    end
  end

  assign w_skip = (cali_mode && (r_chn != {1'b0, cali_chn})) ||
                  (zs_en && (r_data <= zs_thresh));

  always_comb begin
    w_nstate  = r_state;
    w_write   = 1'b0;
    w_word    = '0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   if (r_trig_req) w_nstate = S_HOLDW;
      S_HOLDW:  if (r_cnt == C_HOLD) w_nstate = S_HOLD;
      S_HOLD:   w_nstate = S_SHIFT;
      S_SHIFT:  w_nstate = S_CKLO;
      S_CKLO:   w_nstate = S_CHECK;
      S_CHECK:  w_nstate = (!va_shift_out || (r_chn == C_NCHN)) ? S_TRAIL : S_SETTLE;
      S_SETTLE: if (r_cnt == C_SETTLE) w_nstate = S_CONV;
      S_CONV:   if (r_cnt == 16'd1) w_nstate = S_WLO;
      S_WLO: begin
        if (!adc_nbusy) begin
          w_nstate = S_WHI;
        end else if (r_cnt >= C_TOUT) begin
          w_nstate  = S_TRAIL;
          w_timeout = 1'b1;
        end
      end
      S_WHI: begin
        if (adc_nbusy) begin
          w_nstate = S_WHDR;
        end else if (r_cnt >= C_TOUT) begin
          w_nstate  = S_TRAIL;
          w_timeout = 1'b1;
        end
      end
      S_WHDR: begin
        w_word = {2'b10, r_evt_id, 1'b1, r_chn[6:0]};
        if (w_skip) begin
          w_nstate = S_NEXT;
        end else if (!fifo_full) begin
          w_write  = 1'b1;
          w_nstate = S_WDAT;
        end
      end
      S_WDAT: begin
        w_word = r_data;
        if (!fifo_full) begin
          w_write  = 1'b1;
          w_nstate = S_NEXT;
        end
      end
      S_NEXT:   w_nstate = S_CKLO;
      S_TRAIL: begin
        w_word = {2'b11, r_evt_id, r_nwr | {r_tout, 7'b0}};
        if (!fifo_full) begin
          w_write  = 1'b1;
          w_nstate = S_IDLE;
        end
      end
      default:  w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else if (w_tick) begin
      r_state <= w_nstate;
    end
  end

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_chn     <= '0;
      r_data    <= '0;
      r_nwr     <= '0;
      r_tout    <= 1'b0;
      r_trig_id <= '0;
      r_evt_id  <= '0;
      r_err     <= 1'b0;
      r_hold    <= 1'b0;
      r_shiftb  <= 1'b1;
      r_ckb     <= 1'b1;
      r_dreset  <= 1'b1;
      r_nrc     <= 1'b1;
    end else if (w_tick) begin
      r_cnt <= (w_nstate != r_state) ? 16'd0 : r_cnt + 16'd1;
      if ((r_state == S_IDLE) && (w_nstate == S_HOLDW)) begin
        r_evt_id  <= r_trig_id[5:0];
        r_trig_id <= r_trig_id + 8'd1;
        r_chn     <= '0;
        r_nwr     <= '0;
        r_tout    <= 1'b0;
      end
      if (r_state == S_NEXT) r_chn <= r_chn + 8'd1;
      if ((r_state == S_WHI) && adc_nbusy) r_data <= adc_data;
      if (fifo_we && (r_state == S_WDAT) && (r_nwr != 8'hFF)) r_nwr <= r_nwr + 8'd1;
      if (w_timeout) begin
        r_tout <= 1'b1;
        r_err  <= 1'b1;
      end
      // Line levels only change on state entry, so a stalled write state freezes them.
      case (w_nstate)
        S_IDLE: begin
          r_hold   <= 1'b0;
          r_shiftb <= 1'b1;
          r_ckb    <= 1'b1;
          r_dreset <= 1'b1;
          r_nrc    <= 1'b1;
        end
        S_HOLDW: r_dreset <= 1'b0;
        S_HOLD:  r_hold   <= 1'b1;
        S_SHIFT: r_shiftb <= 1'b0;
        S_CKLO:  r_ckb    <= 1'b0;
        S_CONV: begin
          r_nrc    <= 1'b0;
          r_ckb    <= 1'b1;
          r_shiftb <= 1'b1;
        end
        S_WLO:   r_nrc    <= 1'b1;
        default: ;
      endcase
    end
  end

  assign fifo_we     = w_tick & w_write;
  assign fifo_data   = fifo_we ? w_word : 16'd0;
  assign busy_n      = (r_state == S_IDLE);
  assign err_timeout = r_err;
  assign va_hold     = r_hold;
  assign va_shiftb   = r_shiftb;
  assign va_ckb      = r_ckb;
  assign va_dreset   = r_dreset;
  assign adc_nrc     = r_nrc;

endmodule

// File: tb/tb_va_adc_readout_seq.sv
// tb/tb_va_adc_readout_seq.sv - randomized self-checking bench for va_adc_readout_seq
`timescale 1ns/1ps
module tb_va_adc_readout_seq;

  localparam int N_CHN = 4, CLK_DIV = 4, HOLD_DLY = 16, SETTLE_DLY = 20, TIMEOUT = 255;

  logic        clk_sys = 1'b0;
  logic        rstn = 1'b0;
  logic        trig = 1'b0;
  logic        cali_mode = 1'b0;
  logic [6:0]  cali_chn = '0;
  logic        zs_en = 1'b0;
  logic [15:0] zs_thresh = '0;
  logic        va_hold, va_shiftb, va_ckb, va_dreset, va_shift_out;
  logic        adc_nrc;
  logic        adc_nbusy = 1'b1;
  logic [15:0] adc_data = '0;
  logic [15:0] fifo_data;
  logic        fifo_we;
  logic        fifo_full = 1'b0;
  logic        busy_n, err_timeout;

  int n_tests = 0;
  int n_fail = 0;
  int chain_len = N_CHN;
  int busy_cycles = 3 * CLK_DIV;
  bit adc_stuck = 1'b0;
  int ck_falls = 0;
  int base;
  logic [15:0] chan_vals [N_CHN];
  logic [15:0] got_log [$];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];

  va_adc_readout_seq #(.N_CHN(N_CHN), .CLK_DIV(CLK_DIV), .HOLD_DLY(HOLD_DLY),
                       .SETTLE_DLY(SETTLE_DLY), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .rstn(rstn), .trig(trig), .cali_mode(cali_mode), .cali_chn(cali_chn),
    .zs_en(zs_en), .zs_thresh(zs_thresh), .va_hold(va_hold), .va_shiftb(va_shiftb),
    .va_ckb(va_ckb), .va_dreset(va_dreset), .va_shift_out(va_shift_out), .adc_nrc(adc_nrc),
    .adc_nbusy(adc_nbusy), .adc_data(adc_data), .fifo_data(fifo_data), .fifo_we(fifo_we),
    .fifo_full(fifo_full), .busy_n(busy_n), .err_timeout(err_timeout)
  );

  always #10 clk_sys = ~clk_sys;

  // VA chain: one channel per falling shift clock, empty after chain_len channels.
  always @(negedge va_ckb or posedge va_dreset) begin
    if (va_dreset) ck_falls = 0;
    else ck_falls = ck_falls + 1;
  end
  assign va_shift_out = (ck_falls <= chain_len);

  always @(negedge adc_nrc) begin
    if (!adc_stuck) begin
      @(posedge clk_sys);
      #1 adc_nbusy = 1'b0;
      repeat (busy_cycles) @(posedge clk_sys);
      #1 adc_data = (ck_falls >= 1 && ck_falls <= N_CHN) ? chan_vals[ck_falls-1] : 16'hBAD0;
      adc_nbusy = 1'b1;
    end
  end

  always @(negedge clk_sys) if (fifo_we === 1'b1) got_log.push_back(fifo_data);

  function automatic void model_event(input int id, input int tout_chn);
    int nwr = 0;
    int nch = (chain_len < N_CHN) ? chain_len : N_CHN;
    logic [7:0] idb = id[7:0];
    logic [7:0] tr;
    logic [6:0] kc;
    for (int k = 0; k < nch && k != tout_chn; k++) begin
      kc = k[6:0];
      if (!((cali_mode && kc != cali_chn) || (zs_en && chan_vals[k] <= zs_thresh))) begin
        exp_q.push_back({2'b10, idb[5:0], 1'b1, kc});
        exp_q.push_back(chan_vals[k]);
        nwr++;
      end
    end
    tr = (nwr > 255) ? 8'hFF : nwr[7:0];
    if (tout_chn >= 0 && tout_chn < nch) tr[7] = 1'b1;
    exp_q.push_back({2'b11, idb[5:0], tr});
  endfunction

  task automatic sync_wait(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; trig = 1'b0; fifo_full = 1'b0; cali_mode = 1'b0; zs_en = 1'b0;
    adc_stuck = 1'b0; chain_len = N_CHN; busy_cycles = 3 * CLK_DIV;
    sync_wait(3);
    rstn = 1'b1;
    sync_wait(2);
  endtask

  task automatic start_trig();
    trig = 1'b1;
    sync_wait(3 * CLK_DIV);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_n === 1'b1 && n < 64) begin sync_wait(1); n++; end
    n = 0;
    while (busy_n !== 1'b1 && n < 20000) begin sync_wait(1); n++; end
    n_tests++;
    if (busy_n !== 1'b1) begin n_fail++; $display("FAIL %s done: busy_n=%b, want 1 within bound", name, busy_n); end
    sync_wait(2 * CLK_DIV);
  endtask

  task automatic grab_words();
    got_q.delete();
    for (int i = base; i < got_log.size(); i++) got_q.push_back(got_log[i]);
  endtask

  task automatic test_reset();
    do_reset();
    sync_wait(2 * CLK_DIV);
    n_tests++;
    if ({va_hold, va_shiftb, va_ckb, va_dreset, adc_nrc, fifo_we, busy_n, err_timeout} !== 8'b0111_1010) begin
      n_fail++;
      $display("FAIL reset levels: hold/shiftb/ckb/dreset/nrc/we/busy_n/err = %b, want 01111010",
               {va_hold, va_shiftb, va_ckb, va_dreset, adc_nrc, fifo_we, busy_n, err_timeout});
    end
    n_tests++;
    if (fifo_data !== 16'h0000) begin n_fail++; $display("FAIL reset fifo_data: got %h want 0000", fifo_data); end
  endtask

  task automatic test_basic();
    do_reset();
    foreach (chan_vals[i]) chan_vals[i] = 16'($urandom);
    base = got_log.size(); exp_q.delete();
    model_event(0, -1);
    start_trig(); wait_idle("basic");
    grab_words();
    n_tests++;
    if (got_q.size() !== 9) begin n_fail++; $display("FAIL basic count: got %0d want 9", got_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_tests++;
    if (got_q.size() == 9 && got_q[8] !== 16'hC004) begin n_fail++; $display("FAIL basic trailer: got %h want C004", got_q[8]); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    foreach (chan_vals[i]) chan_vals[i] = 16'($urandom);
    base = got_log.size(); exp_q.delete();
    model_event(0, -1); model_event(1, -1);
    start_trig();
    while (ck_falls < 2 && n < 4000) begin sync_wait(1); n++; end
    start_trig();
    wait_idle("b2b first");
    start_trig(); wait_idle("b2b second");
    grab_words();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_tests++;
    if (got_q.size() == 18 && (got_q[8] !== 16'hC004 || got_q[17] !== 16'hC104)) begin
      n_fail++; $display("FAIL b2b trailers: got %h %h want C004 C104", got_q[8], got_q[17]);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit bad_we = 0, bad_frz = 0;
    logic ckb0, nrc0;
    do_reset();
    foreach (chan_vals[i]) chan_vals[i] = 16'($urandom);
    base = got_log.size(); exp_q.delete();
    model_event(0, -1);
    start_trig();
    while (got_log.size() < base + 1 && n < 8000) begin @(negedge clk_sys); n++; end
    @(posedge clk_sys); #1 fifo_full = 1'b1;
    ckb0 = va_ckb; nrc0 = adc_nrc;
    repeat (50) begin
      @(negedge clk_sys);
      if (fifo_we !== 1'b0) bad_we = 1;
      if (va_ckb !== ckb0 || adc_nrc !== nrc0 || busy_n !== 1'b0) bad_frz = 1;
    end
    #1 fifo_full = 1'b0;
    n_tests++;
    if (bad_we) begin n_fail++; $display("FAIL bp strobe: fifo_we seen while full, want none"); end
    n_tests++;
    if (bad_frz) begin n_fail++; $display("FAIL bp freeze: va_ckb/adc_nrc/busy_n changed while full, want held %b/%b/0", ckb0, nrc0); end
    wait_idle("bp");
    grab_words();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_suppress();
    do_reset();
    chan_vals[0] = 16'd50; chan_vals[1] = 16'd200; chan_vals[2] = 16'd100; chan_vals[3] = 16'd300;
    zs_en = 1'b1; zs_thresh = 16'd100;
    base = got_log.size(); exp_q.delete();
    model_event(0, -1);
    start_trig(); wait_idle("zs");
    grab_words();
    n_tests++;
    if (got_q.size() !== 5) begin n_fail++; $display("FAIL zs count: got %0d want 5", got_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL zs word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_tests++;
    if (got_q.size() == 5 && (got_q[0] !== 16'h8081 || got_q[2] !== 16'h8083 || got_q[4] !== 16'hC002)) begin
      n_fail++; $display("FAIL zs frame: got %h %h %h want 8081 8083 C002", got_q[0], got_q[2], got_q[4]);
    end
  endtask

  task automatic test_cali();
    do_reset();
    foreach (chan_vals[i]) chan_vals[i] = 16'($urandom);
    cali_mode = 1'b1; cali_chn = 7'd2;
    base = got_log.size(); exp_q.delete();
    model_event(0, -1);
    start_trig(); wait_idle("cali");
    grab_words();
    n_tests++;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL cali count: got %0d want 3", got_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL cali word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_tests++;
    if (got_q.size() == 3 && (got_q[0] !== 16'h8082 || got_q[1] !== chan_vals[2] || got_q[2] !== 16'hC001)) begin
      n_fail++; $display("FAIL cali frame: got %h %h %h want 8082 %h C001", got_q[0], got_q[1], got_q[2], chan_vals[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 6; it++) begin
      foreach (chan_vals[i]) chan_vals[i] = 16'($urandom_range(0, 400));
      zs_en = 1'($urandom_range(0, 1)); zs_thresh = 16'($urandom_range(0, 400));
      cali_mode = 1'($urandom_range(0, 1)); cali_chn = 7'($urandom_range(0, 5));
      chain_len = $urandom_range(0, N_CHN + 1);
      busy_cycles = CLK_DIV * $urandom_range(3, 5);
      base = got_log.size(); exp_q.delete();
      model_event(it, -1);
      start_trig(); wait_idle("random");
      grab_words();
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random%0d count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_tests++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random%0d word%0d: got %h want %h", it, i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout_reset();
    do_reset();
    foreach (chan_vals[i]) chan_vals[i] = 16'($urandom);
    adc_stuck = 1'b1;
    base = got_log.size(); exp_q.delete();
    model_event(0, 0);
    start_trig(); wait_idle("timeout");
    grab_words();
    n_tests++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0] || got_q[0] !== 16'hC080) begin
      n_fail++; $display("FAIL timeout trailer: got %0d words first %h, want 1 word C080", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
    n_tests++;
    if (err_timeout !== 1'b1 || busy_n !== 1'b1) begin n_fail++; $display("FAIL timeout flags: err=%b busy_n=%b want 1 1", err_timeout, busy_n); end
    adc_stuck = 1'b0;
    start_trig(); wait_idle("timeout sticky");
    n_tests++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout sticky: err=%b want 1", err_timeout); end
    start_trig();
    sync_wait(120);
    n_tests++;
    if (va_hold !== 1'b1 || busy_n !== 1'b0) begin n_fail++; $display("FAIL midreset pre: hold=%b busy_n=%b want 1 0", va_hold, busy_n); end
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({va_hold, va_shiftb, va_ckb, va_dreset, adc_nrc, fifo_we, busy_n, err_timeout, fifo_data} !== {8'b0111_1010, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset levels: hold/shiftb/ckb/dreset/nrc/we/busy_n/err=%b data=%h want 01111010 0000",
               {va_hold, va_shiftb, va_ckb, va_dreset, adc_nrc, fifo_we, busy_n, err_timeout}, fifo_data);
    end
    sync_wait(3);
    rstn = 1'b1;
    base = got_log.size();
    sync_wait(100);
    n_tests++;
    if (got_log.size() !== base) begin n_fail++; $display("FAIL midreset trailer: %0d words after reset, want 0", got_log.size() - base); end
    start_trig(); wait_idle("post reset");
    grab_words();
    n_tests++;
    if (got_q.size() !== 9 || got_q[8] !== 16'hC004) begin
      n_fail++; $display("FAIL post reset id: %0d words last %h, want 9 words ending C004", got_q.size(), got_q.size() > 0 ? got_q[got_q.size()-1] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_zero_suppress();
    test_cali();
    test_random();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
